// File: rtl/host_req_arbiter_if.sv
// NASTI (AXI4-style) channel bundle used between the host-request arbiter and the host slave.
// The master drives AW/W, the B ready and the AR/R tie-offs; the slave drives the remainder.
interface nasti_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [USER_WIDTH-1:0]   aw_user;

    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;

    logic                    b_valid;
    logic                    b_ready;
    logic [1:0]              b_resp;
    logic [ID_WIDTH-1:0]     b_id;
    logic [USER_WIDTH-1:0]   b_user;

    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [USER_WIDTH-1:0]   ar_user;

    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [ID_WIDTH-1:0]     r_id;
    logic [USER_WIDTH-1:0]   r_user;

    modport master (
        output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_id, aw_user,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last, w_user,
        input  w_ready,
        input  b_valid, b_resp, b_id, b_user,
        output b_ready,
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_id, ar_user,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_last, r_id, r_user,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_id, aw_user,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last, w_user,
        output w_ready,
        output b_valid, b_resp, b_id, b_user,
        input  b_ready,
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_id, ar_user,
        output ar_ready,
        output r_valid, r_data, r_resp, r_last, r_id, r_user,
        input  r_ready
    );
endinterface

// File: rtl/host_req_arbiter.sv
// Round-robin arbiter funnelling NREQ requesters onto one NASTI write port, one
// single-beat AW/W/B transaction at a time, with a sticky error flag on bad responses.
module host_req_arbiter #(
    parameter int          NREQ       = 4,
    parameter int          ID_WIDTH   = 1,
    parameter int          USER_WIDTH = 1,
    parameter int          BASE_ID    = 0,
    parameter logic [31:0] HOST_ADDR  = 32'h0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 busy,
    output logic                 err,
    output logic [3:0]           err_id,
    nasti_channel.master         nasti
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  winner_q, winner_d;
    logic [15:0]       payload_q, payload_d;
    logic [15:0]       hostId_q, hostId_d;
    logic              err_q, err_d;
    logic [3:0]        errId_q, errId_d;

    logic              found;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W:0]    candSum;
    logic [IDX_W-1:0]  cand;
    logic [NREQ-1:0]   grant;
    logic              bDone;

    // Scan the requesters starting at ptr, wrapping modulo NREQ; first valid one wins.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        candSum = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            candSum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (candSum >= (IDX_W+1)'(NREQ)) begin
                candSum = candSum - (IDX_W+1)'(NREQ);
            end
            cand = candSum[IDX_W-1:0];
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        winner_d  = winner_q;
        payload_d = payload_q;
        hostId_d  = hostId_q;
        err_d     = err_q;
        errId_d   = errId_q;
        grant     = '0;
        bDone     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant[pick] = 1'b1;
                    winner_d    = pick;
                    payload_d   = req_data[16*pick +: 16];
                    hostId_d    = 16'(BASE_ID) + 16'(pick);
                    ptr_d       = (pick == IDX_W'(NREQ-1)) ? '0 : pick + IDX_W'(1);
                    state_d     = S_AW;
                end
            end
            S_AW: begin
                if (nasti.aw_ready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                // b_ready is already high here, so a same-cycle response retires the transaction.
                if (nasti.w_ready) begin
                    if (nasti.b_valid) begin
                        bDone   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (nasti.b_valid) begin
                    bDone   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bDone && (nasti.b_resp != 2'b00) && !err_q) begin
            err_d   = 1'b1;
            errId_d = 4'(winner_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            winner_q  <= '0;
            payload_q <= '0;
            hostId_q  <= '0;
            err_q     <= 1'b0;
            errId_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            winner_q  <= winner_d;
            payload_q <= payload_d;
            hostId_q  <= hostId_d;
            err_q     <= err_d;
            errId_q   <= errId_d;
        end
    end

    // Grant is combinational from req_valid, so it is also masked by reset to stay low while held.
    assign req_ready = grant & {NREQ{rstn}};
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign err_id    = errId_q;

    assign nasti.aw_valid  = (state_q == S_AW);
    assign nasti.aw_addr   = HOST_ADDR;
    assign nasti.aw_len    = 8'd0;
    assign nasti.aw_size   = 3'd3;
    assign nasti.aw_burst  = 2'b01;
    assign nasti.aw_lock   = 1'b0;
    assign nasti.aw_cache  = 4'd0;
    assign nasti.aw_prot   = 3'd0;
    assign nasti.aw_qos    = 4'd0;
    assign nasti.aw_region = 4'd0;
    assign nasti.aw_id     = ID_WIDTH'(0);
    assign nasti.aw_user   = USER_WIDTH'(0);

    assign nasti.w_valid = (state_q == S_W);
    assign nasti.w_data  = 64'({hostId_q, payload_q});
    assign nasti.w_strb  = '1;
    assign nasti.w_last  = 1'b1;
    assign nasti.w_user  = USER_WIDTH'(0);

    assign nasti.b_ready = (state_q == S_W) || (state_q == S_B);

    assign nasti.ar_valid  = 1'b0;
    assign nasti.ar_addr   = '0;
    assign nasti.ar_len    = 8'd0;
    assign nasti.ar_size   = 3'd0;
    assign nasti.ar_burst  = 2'b00;
    assign nasti.ar_lock   = 1'b0;
    assign nasti.ar_cache  = 4'd0;
    assign nasti.ar_prot   = 3'd0;
    assign nasti.ar_qos    = 4'd0;
    assign nasti.ar_region = 4'd0;
    assign nasti.ar_id     = ID_WIDTH'(0);
    assign nasti.ar_user   = USER_WIDTH'(0);
    assign nasti.r_ready   = 1'b0;

endmodule

// File: tb/tb_host_req_arbiter.sv
// Randomized scoreboard bench for host_req_arbiter: a transaction-level model predicts
// grants, busy and error state, and a separate monitor checks every AW/W beat on the bus.
module tb_host_req_arbiter;

    localparam int          NREQ      = 4;
    localparam int          BASE_ID   = 8;
    localparam logic [31:0] HOST_ADDR = 32'h0000_4A00;

    logic                  clk       = 1'b0;
    logic                  rstn      = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [16*NREQ-1:0]    req_data  = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  busy;
    logic                  err;
    logic [3:0]            err_id;

    nasti_channel #(.ID_WIDTH(1), .USER_WIDTH(1)) nasti ();

    host_req_arbiter #(
        .NREQ(NREQ), .ID_WIDTH(1), .USER_WIDTH(1), .BASE_ID(BASE_ID), .HOST_ADDR(HOST_ADDR)
    ) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .busy(busy), .err(err), .err_id(err_id), .nasti(nasti)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] payload;
    } txn_t;

    int   checks = 0;
    int   errors = 0;
    txn_t expQ[$];

    int   mPtr = 0;
    int   mCur = 0;
    bit   mBusy = 0;
    bit   mErr = 0;
    int   mErrId = 0;
    bit   prevGranted = 0;
    bit   pending[NREQ];
    logic [15:0] pay[NREQ];

    int awPct = 100;
    int wPct = 100;
    int combPct = 0;
    int awStall = -1;
    int bStall = -1;
    int bMax = 0;
    int errIdx = -1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        mPtr = 0;
        mCur = 0;
        mBusy = 0;
        mErr = 0;
        mErrId = 0;
        prevGranted = 0;
        expQ.delete();
        for (int i = 0; i < NREQ; i++) pending[i] = 0;
    endtask

    task automatic setSlave(input int aw, input int w, input int comb, input int bm);
        awPct = aw;
        wPct = w;
        combPct = comb;
        bMax = bm;
    endtask

    // One loop iteration per clock: drive requests after the edge, then predict and compare at the negedge.
    task automatic applyStimulus(input int cycles, input int raisePct, input bit gapCheck);
        int lastGrant = -1;
        for (int c = 0; c < cycles; c++) begin
            logic [NREQ-1:0] expGrant;
            bit wasBusy;
            int winner;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && ($urandom_range(99) < raisePct)) begin
                    pending[i] = 1;
                    pay[i] = 16'($urandom);
                end else if (pending[i] && raisePct > 0 && raisePct < 100 && ($urandom_range(99) < 3)) begin
                    pending[i] = 0;
                end
                req_valid[i] = pending[i];
                req_data[16*i +: 16] = pay[i];
            end
            @(negedge clk);
            expGrant = '0;
            wasBusy = mBusy;
            winner = -1;
            checkOutput("busy", busy, wasBusy);
            checkOutput("err", err, mErr);
            checkOutput("err_id", err_id, mErrId);
            if (prevGranted) checkOutput("aw_after_grant", nasti.aw_valid, 1);
            prevGranted = 0;
            if (!mBusy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (winner < 0 && req_valid[(mPtr + k) % NREQ]) winner = (mPtr + k) % NREQ;
                end
            end
            if (winner >= 0) begin
                expGrant[winner] = 1'b1;
                expQ.push_back('{idx: 4'(winner), payload: req_data[16*winner +: 16]});
                mCur = winner;
                mPtr = (winner + 1) % NREQ;
                mBusy = 1;
                prevGranted = 1;
                if (gapCheck && lastGrant >= 0) begin
                    checkOutput("grant_gap_3_to_4", c - lastGrant, ((c - lastGrant) < 3) ? 3 : ((c - lastGrant) > 4) ? 4 : c - lastGrant);
                end
                lastGrant = c;
            end
            checkOutput("grant", req_ready, expGrant);
            if (wasBusy && nasti.b_valid && nasti.b_ready) begin
                if (nasti.b_resp != 2'b00 && !mErr) begin
                    mErr = 1;
                    mErrId = mCur;
                end
                mBusy = 0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_valid[i]) pending[i] = 0;
            end
        end
    endtask

    // Host slave: wait states on AW/W, delayed or same-cycle B, error response keyed on host id.
    initial begin
        int awCnt = 0;
        bit bPend = 0;
        int bCnt = 0;
        logic [15:0] curHost = '0;
        nasti.aw_ready = 0; nasti.w_ready = 0; nasti.b_valid = 0; nasti.b_resp = 0;
        nasti.b_id = 0; nasti.b_user = 0; nasti.ar_ready = 0; nasti.r_valid = 0;
        nasti.r_data = 0; nasti.r_resp = 0; nasti.r_last = 0; nasti.r_id = 0; nasti.r_user = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                nasti.aw_ready = 0; nasti.w_ready = 0; nasti.b_valid = 0; nasti.b_resp = 0;
                bPend = 0;
                awCnt = 0;
            end else begin
                if (awStall >= 0) nasti.aw_ready = nasti.aw_valid && (awCnt >= awStall);
                else nasti.aw_ready = ($urandom_range(99) < awPct);
                if (nasti.w_valid) curHost = nasti.w_data[31:16];
                if (bPend) begin
                    nasti.w_ready = 0;
                    nasti.b_valid = (bCnt == 0);
                    if (bCnt > 0) bCnt--;
                end else begin
                    nasti.w_ready = ($urandom_range(99) < wPct);
                    nasti.b_valid = nasti.w_valid && nasti.w_ready && (bStall < 0) && ($urandom_range(99) < combPct);
                end
                nasti.b_resp = (errIdx >= 0 && int'(curHost) == BASE_ID + errIdx) ? 2'b10 : 2'b00;
            end
            @(negedge clk);
            if (!rstn) begin
                bPend = 0;
                awCnt = 0;
            end else begin
                if (nasti.aw_valid && !nasti.aw_ready) awCnt++;
                else awCnt = 0;
                if (bPend && nasti.b_valid && nasti.b_ready) begin
                    bPend = 0;
                end else if (nasti.w_valid && nasti.w_ready && !nasti.b_valid) begin
                    bPend = 1;
                    bCnt = (bStall >= 0) ? bStall : $urandom_range(bMax);
                end
            end
        end
    end

    // Bus monitor: pops the scoreboard on every W beat and checks channel ordering and stability.
    initial begin
        bit awPend = 0;
        bit wPend = 0;
        bit awHsPrev = 0;
        logic [31:0] awAddrPrev = '0;
        logic [63:0] wDataPrev = '0;
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                awPend = 0;
                wPend = 0;
                awHsPrev = 0;
            end else begin
                checkOutput("ar_r_tieoff", {nasti.ar_valid, nasti.r_ready}, 2'b00);
                if (awPend) begin
                    checkOutput("aw_hold", nasti.aw_valid, 1);
                    checkOutput("aw_addr_stable", nasti.aw_addr, awAddrPrev);
                end
                if (wPend) begin
                    checkOutput("w_hold", nasti.w_valid, 1);
                    checkOutput("w_data_stable", nasti.w_data, wDataPrev);
                end
                if (awHsPrev) checkOutput("w_after_aw", {nasti.w_valid, nasti.aw_valid}, 2'b10);
                if (nasti.aw_valid) checkOutput("aw_w_exclusive", nasti.w_valid, 0);
                awHsPrev = 0;
                if (nasti.aw_valid && nasti.aw_ready) begin
                    checkOutput("aw_addr", nasti.aw_addr, HOST_ADDR);
                    checkOutput("aw_len_size_burst", {nasti.aw_len, nasti.aw_size, nasti.aw_burst}, {8'd0, 3'd3, 2'b01});
                    checkOutput("aw_id_user", {nasti.aw_id, nasti.aw_user}, 2'b00);
                    awHsPrev = 1;
                end
                if (nasti.w_valid && nasti.w_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL w_unexpected: actual=extra W beat 0x%0h required=none at %0t", nasti.w_data, $time);
                    end else begin
                        t = expQ.pop_front();
                        checkOutput("w_data", nasti.w_data, {32'h0, 16'(BASE_ID + int'(t.idx)), t.payload});
                        checkOutput("w_last_strb", {nasti.w_last, nasti.w_strb}, {1'b1, 8'hFF});
                    end
                end
                awPend = nasti.aw_valid && !nasti.aw_ready;
                awAddrPrev = nasti.aw_addr;
                wPend = nasti.w_valid && !nasti.w_ready;
                wDataPrev = nasti.w_data;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetModel();
        req_valid = '1;
        @(negedge clk);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_busy_err", {busy, err, err_id}, 0);
        checkOutput("rst_bus_valids", {nasti.aw_valid, nasti.w_valid, nasti.b_ready}, 0);
        req_valid = '0;
        @(posedge clk);
        #2 rstn = 1;

        $display("[TB] single request from requester 2");
        setSlave(100, 100, 0, 0);
        pending[2] = 1;
        pay[2] = 16'h1234;
        applyStimulus(8, 0, 0);

        $display("[TB] all requesters valid, zero-wait slave");
        setSlave(100, 100, 50, 0);
        applyStimulus(40, 100, 1);

        $display("[TB] AW stall 5, B stall 3");
        awStall = 5;
        bStall = 3;
        applyStimulus(40, 100, 0);
        awStall = -1;
        bStall = -1;

        $display("[TB] random traffic, random slave");
        setSlave(60, 60, 30, 3);
        applyStimulus(150, 35, 0);

        $display("[TB] error response on requester 1, then on requester 2");
        setSlave(100, 100, 50, 0);
        errIdx = 1;
        applyStimulus(30, 100, 0);
        errIdx = 2;
        applyStimulus(30, 100, 0);
        errIdx = -1;
        applyStimulus(20, 100, 0);

        $display("[TB] reset while in the W phase");
        setSlave(100, 0, 0, 0);
        applyStimulus(10, 100, 0);
        @(posedge clk);
        #2;
        checkOutput("pre_reset_w_valid", nasti.w_valid, 1);
        rstn = 0;
        #1;
        checkOutput("reset_w_valid", nasti.w_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_err", {err, err_id}, 0);
        resetModel();
        req_valid = '0;
        setSlave(100, 100, 50, 0);
        repeat (2) @(negedge clk);
        pending[0] = 1;
        pending[3] = 1;
        pay[0] = 16'($urandom);
        pay[3] = 16'($urandom);
        @(posedge clk);
        #3 rstn = 1;
        applyStimulus(12, 0, 0);

        $display("[TB] random traffic after reset, then drain");
        setSlave(70, 70, 30, 2);
        applyStimulus(80, 40, 0);
        for (int i = 0; i < NREQ; i++) pending[i] = 0;
        setSlave(100, 100, 0, 0);
        applyStimulus(30, 0, 0);
        if (mBusy) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: actual=transaction outstanding required=idle");
        end
        checkOutput("drain_busy", busy, 0);
        checkOutput("w_beats_missing", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/host_req_arbiter.md
# host_req_arbiter

Round-robin arbiter that shares the single host-request NASTI write port among NREQ on-chip requesters, such as per-core host-interface agents. Each accepted request becomes one single-beat NASTI write to the host target. The write data packs the host id into bits above 16 and the 16-bit payload into bits [15:0]. The block sits between the requesters and the host slave, and sequences each AW/W/B exchange strictly one transaction at a time.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..16)
- ID_WIDTH, 1: NASTI id width
- USER_WIDTH, 1: NASTI user width
- BASE_ID, 0: host id given to requester 0; requester i uses BASE_ID+i
- HOST_ADDR, 0: constant write address

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- req_valid  input  NREQ  request valid, one bit per requester
- req_data  input  16*NREQ  payload; requester i uses [16*i+15:16*i]
- req_ready  output  NREQ  one-hot grant pulse; the handshake completes when valid && ready
- busy  output  1  high while a transaction is outstanding
- err  output  1  sticky; set when b_resp != 0
- err_id  output  4  requester index of the first erroring transaction
- nasti  nasti_channel.master  -  AW/W/B master; AR/R channels are tied off

## Operation
- FSM has four states: IDLE, AW, W, B.
- IDLE:
  - If any req_valid is set, choose the winner by round-robin, starting the search at index ptr.
  - Assert req_ready[winner] combinationally in that cycle.
  - Latch the payload, the winner index and host id = BASE_ID+winner.
  - Set ptr = (winner+1) mod NREQ, then go to AW.
  - With no request: stay in IDLE, all req_ready low.
- AW:
  - Drive aw_valid=1, aw_addr=HOST_ADDR, aw_len=0, aw_size=3, aw_burst=INCR, aw_id=0, aw_user=0. All other AW fields are 0.
  - On aw_ready, go to W.
- W:
  - Drive w_valid=1, w_last=1, w_strb all ones, w_user=0.
  - w_data = zero-extended {host_id, payload16}: bits [15:0]=payload, bits [31:16]=host_id, upper bits 0.
  - b_ready=1 in this state.
  - On w_ready: if b_valid is also high that cycle, go to IDLE; otherwise go to B.
- B: b_ready=1. On b_valid, go to IDLE.
- On every B handshake with b_resp != 0: if err is still clear, set err=1 and err_id=latched winner. err is cleared only by reset.
- busy=1 in AW, W and B.
- ar_valid=0 and r_ready=0 always.
- AW and W are never asserted in the same cycle. aw_valid/w_valid, once raised, stay high with stable payload until their handshake completes.

## Timing
- Reset values:
  - state=IDLE, ptr=0
  - req_ready=0, busy=0, err=0, err_id=0
  - aw_valid=0, w_valid=0, b_ready=0
  - latched data=0
- Reset asserted mid-transaction aborts it immediately. Outputs return to reset values asynchronously. No retry is attempted after reset.
- Latency with a slave responding with zero wait states:
  - grant in cycle 0
  - aw_valid in cycle 1
  - w_valid in cycle 2
  - B accepted in cycle 2 (combinational b_valid) or in cycle 3
  - IDLE, with a new grant possible, the cycle after that
- Peak rate: one transaction per 3-4 cycles.
- Wait states on aw_ready, w_ready or b_valid stretch the corresponding state indefinitely. There is no timeout.
- Simultaneous requests: exactly one grant per IDLE cycle. Requesters that lose keep req_valid held. ptr guarantees each pending requester is served within NREQ transactions.
- A request that drops valid before it is granted is ignored. Requests arriving while busy wait until the next IDLE.
- ptr wraps from NREQ-1 to 0.

## Test plan
- Single request: req_valid[2]=1, payload 0x1234, BASE_ID=0 -> req_ready[2] pulses in cycle 0; one AW with addr=HOST_ADDR, len=0; w_data=0x0002_1234, w_last=1; busy low after B.
- All four valid continuously -> grant order 0,1,2,3,0; each w_data[31:16] matches its index; no requester is granted twice before the others are served.
- Slave stalls aw_ready for 5 cycles and b_valid for 3 cycles -> aw_valid and w_data stay stable throughout; exactly one W beat is sent; next grant only after B.
- b_resp=2 on the transaction for requester 1, then OKAY on later ones -> err=1 and err_id=1, both persisting through the subsequent OKAY transactions.
- rstn pulsed low while in W -> w_valid, busy and req_ready drop immediately; after release, state=IDLE and ptr=0, so the next simultaneous request from 0 and 3 grants 0.
- Back-to-back against a zero-wait slave, BASE_ID=8 -> host ids 8..11 are seen in the W data; a new grant appears every 3-4 cycles.
